// File: rtl/integer_shift_multiplier.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per enabled cycle, LSB first.
// Result lands in a holding register so the product output never shows partial sums.
module integer_shift_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH:0]    acc;
    logic [WIDTH-1:0]  msr;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH:0]    sum;
    logic [2*WIDTH:0]  shifted;
    logic              last_step;

    // The accumulator carry bit is always zero after the shift, so adding the
    // full accumulator gives the same sum as adding only its low WIDTH bits.
    function automatic logic [WIDTH:0] add_step(input logic [WIDTH:0]   acc_in,
                                                input logic [WIDTH-1:0] a,
                                                input logic             bit0);
        add_step = acc_in + {1'b0, (bit0 ? a : {WIDTH{1'b0}})};
    endfunction

    always_comb begin
        sum       = add_step(acc, mcand, msr[0]);
        shifted   = {sum, msr} >> 1;
        last_step = (cnt == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand   <= '0;
            acc     <= '0;
            msr     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (ena) begin
            if (state != RUN) begin
                if (start) begin
                    mcand <= multiplicand;
                    msr   <= multiplier;
                    acc   <= '0;
                    cnt   <= CNT_W'(WIDTH);
                end
            end else begin
                acc <= shifted[2*WIDTH:WIDTH];
                msr <= shifted[WIDTH-1:0];
                cnt <= cnt - CNT_W'(1);
                if (last_step) begin
                    product <= shifted[2*WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_integer_shift_multiplier.sv
// Scoreboard bench for integer_shift_multiplier: directed scenarios then randomized traffic.
// Expected products and completion times come from an enabled-edge-count model.
module tb_integer_shift_multiplier;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2*W-1:0]   product;
    logic             busy;
    logic             done;

    integer_shift_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] prod;
        int             at;
    } exp_t;

    exp_t           sb[$];
    int             errors = 0;
    int             checks = 0;
    int             ecount = 0;
    int             pending_end = 0;
    bit             pending = 1'b0;
    bit             model_live = 1'b0;
    logic [2*W-1:0] cur_exp = '0;
    logic [2*W-1:0] last_prod = '0;
    int             last_pop = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation accepted at enabled edge e completes at edge e+W;
    // the machine accepts a new start only when no operation is still running.
    always @(posedge clk) begin
        if (!rst) begin
            sb.delete();
            pending    = 1'b0;
            last_prod  = '0;
            model_live = 1'b1;
        end else if (ena) begin
            ecount++;
            if (pending && ecount == pending_end) last_prod = cur_exp;
            if (start && (!pending || ecount > pending_end)) begin
                cur_exp     = (2*W)'(a) * (2*W)'(b);
                pending     = 1'b1;
                pending_end = ecount + W;
                sb.push_back('{prod: cur_exp, at: pending_end});
            end
        end
    end

    // Monitor: outputs sampled mid-cycle; each done pulse pops one expected result
    always @(negedge clk) begin
        if (model_live) begin
            chk("busy", 64'(busy), 64'(pending && ecount < pending_end));
            chk("done", 64'(done), 64'(pending && ecount == pending_end));
            chk("product_hold", 64'(product), 64'(last_prod));
            if (done === 1'b1 && last_pop != ecount) begin
                last_pop = ecount;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_product", 64'(product), 64'(e.prod));
                    chk("sb_time", 64'(ecount), 64'(e.at));
                end
            end
        end
    end

    task automatic go(input logic [W-1:0] x, input logic [W-1:0] y);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        int n;
        n = 0;
        nbusy = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_done_timeout", 64'(n), 64'(0));
    endtask

    initial begin
        int nb;
        int edges;
        int dcount;
        rst = 1'b0;
        ena = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("reset_product", 64'(product), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        rst = 1'b1;

        go(8'd13, 8'd11);
        wait_done(nb);
        chk("p_13x11", 64'(product), 64'(143));
        chk("busy_cycles", 64'(nb), 64'(8));
        @(negedge clk);

        go(8'd255, 8'd255);
        wait_done(nb);
        chk("p_255x255", 64'(product), 64'(65025));
        @(negedge clk);
        go(8'd0, 8'd200);
        wait_done(nb);
        chk("p_0x200", 64'(product), 64'(0));
        @(negedge clk);

        // starts during RUN must be ignored
        go(8'd13, 8'd11);
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done(nb);
        chk("p_ignore_start", 64'(product), 64'(143));
        @(negedge clk);

        // reset mid-operation
        go(8'd100, 8'd77);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_product", 64'(product), 64'(0));
        rst = 1'b1;
        repeat (12) @(negedge clk);

        // ena toggling every cycle
        a = 8'd7;
        b = 8'd9;
        start = 1'b1;
        ena = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ena = 1'b0;
        edges = 0;
        while (edges < 100) begin
            @(negedge clk);
            edges++;
            if (done === 1'b1) break;
            ena = ~ena;
        end
        chk("ena_edges", 64'(edges), 64'(16));
        chk("p_7x9", 64'(product), 64'(63));
        ena = 1'b1;
        @(negedge clk);

        // start held high: a result every 9th enabled cycle
        a = 8'd3;
        b = 8'd5;
        start = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcount++;
                chk("p_3x5", 64'(product), 64'(15));
            end
        end
        start = 1'b0;
        chk("held_done_count", 64'(dcount), 64'(4));
        wait_done(nb);
        @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            start = ($urandom_range(0, 3) == 0);
            ena = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 63) != 0);
            @(negedge clk);
        end
        rst = 1'b1;
        ena = 1'b1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
